// File: rtl/cpu_pkg.sv
// Shared decode constants and FSM state type for the IF/ID stage.
package cpu_pkg;

  localparam int unsigned REG_W = 6;

  // Register-field positions inside a 32-bit instruction word
  localparam int unsigned RS_HI = 21;
  localparam int unsigned RS_LO = 16;
  localparam int unsigned RT_HI = 15;
  localparam int unsigned RT_LO = 10;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/ifid_hazard_buff_if.sv
// Fetch-to-decode bus seen by the IF/ID buffer, plus its hazard-control sideband.
interface ifid_hazard_buff_if;
  import cpu_pkg::*;

  logic [31:0]      iPC;
  logic [31:0]      iInstr;
  logic             iValid;
  logic             iStall;
  logic             iBranchTaken;
  logic             iEXmemRead;
  logic [REG_W-1:0] iEXRd;
  logic [31:0]      oPC;
  logic [31:0]      oInstr;
  logic             oValid;
  logic             oPCWrite;
  logic             oBubble;
  logic [15:0]      oStallCount;

  modport master (
    output iPC, iInstr, iValid, iStall, iBranchTaken, iEXmemRead, iEXRd,
    input  oPC, oInstr, oValid, oPCWrite, oBubble, oStallCount
  );

  modport slave (
    input  iPC, iInstr, iValid, iStall, iBranchTaken, iEXmemRead, iEXRd,
    output oPC, oInstr, oValid, oPCWrite, oBubble, oStallCount
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use compare between the instruction held in IF/ID and the load sitting in ID/EX.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             valid_i,
  input  logic             exMemRead_i,
  input  logic [REG_W-1:0] exRd_i,
  output logic             hazard_o
);

  // r0 is hard-wired, so a load targeting it can never create a dependency
  assign hazard_o = valid_i && exMemRead_i && (exRd_i != '0) &&
                    ((exRd_i == rs_i) || (exRd_i == rt_i));

endmodule

// File: rtl/ifid_hazard_buff.sv
// IF/ID pipeline register with load-use stall insertion, branch squash and a stall counter.
module ifid_hazard_buff
  import cpu_pkg::*;
#(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [31:0] NOP          = NOP_WORD
) (
  input logic               clock,
  input logic               reset,
  ifid_hazard_buff_if.slave bus
);

  localparam logic [2:0] STALL_RELOAD = 3'(STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [15:0] stallCount_q;
  logic [15:0] stallCount_d;
  logic        hazardRaw;
  logic        hazard;
  logic        bubble;

  hazard_detect u_hazard_detect (
    .rs_i        (instr_q[RS_HI:RS_LO]),
    .rt_i        (instr_q[RT_HI:RT_LO]),
    .valid_i     (valid_q),
    .exMemRead_i (bus.iEXmemRead),
    .exRd_i      (bus.iEXRd),
    .hazard_o    (hazardRaw)
  );

  assign hazard = (state_q == RUN) && hazardRaw;

  // Reset gates the combinational controls so a reset landing mid-STALL cannot leak a bubble
  assign bubble       = !reset && !bus.iBranchTaken && (hazard || (state_q == STALL));
  assign bus.oPCWrite = reset || bus.iBranchTaken ||
                        !(bus.iStall || hazard || (state_q == STALL));
  assign bus.oBubble  = bubble;

  assign stallCount_d = (bubble && !bus.iStall && (stallCount_q != 16'hFFFF)) ?
                        stallCount_q + 16'd1 : stallCount_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      pc_q         <= '0;
      instr_q      <= NOP;
      valid_q      <= 1'b0;
      stallCount_q <= '0;
    end else begin
      stallCount_q <= stallCount_d;
      if (bus.iBranchTaken) begin
        instr_q <= NOP;
        valid_q <= 1'b0;
        if (FLUSH_CYCLES > 1) begin
          cnt_q   <= FLUSH_RELOAD;
          state_q <= FLUSH;
        end else begin
          state_q <= RUN;
        end
      end else if (!bus.iStall) begin
        unique case (state_q)
          RUN: begin
            if (hazard) begin
              if (STALL_CYCLES > 1) begin
                cnt_q   <= STALL_RELOAD;
                state_q <= STALL;
              end
            end else begin
              pc_q    <= bus.iPC;
              instr_q <= bus.iValid ? bus.iInstr : NOP;
              valid_q <= bus.iValid;
            end
          end
          STALL: begin
            if (cnt_q <= 3'd1) begin
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          FLUSH: begin
            instr_q <= NOP;
            valid_q <= 1'b0;
            if (cnt_q <= 3'd1) begin
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign bus.oPC         = pc_q;
  assign bus.oInstr      = instr_q;
  assign bus.oValid      = valid_q;
  assign bus.oStallCount = stallCount_q;

endmodule

// File: tb/tb_ifid_hazard_buff.sv
// Vector table plus scoreboard for two parameterisations of the IF/ID hazard buffer.
module tb_ifid_hazard_buff;

  localparam logic [31:0] I0 = 32'h1100_0000;
  localparam logic [31:0] I1 = 32'h0005_1C00;
  localparam logic [31:0] I2 = 32'h0003_0800;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        stall;
    logic        br;
    logic        memRead;
    logic [5:0]  rd;
    logic        expPCWrite;
    logic        expBubble;
    logic [31:0] expPC;
    logic [31:0] expInstr;
    logic        expValid;
    logic [15:0] expCount;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [15:0] cnt;
    int          idx;
  } exp_t;

  logic clock;
  logic reset;
  int   nVectors;
  int   nMiscompares;
  vec_t vecs[$];
  exp_t sbQ[$];

  ifid_hazard_buff_if busA ();
  ifid_hazard_buff_if busB ();

  ifid_hazard_buff #(.STALL_CYCLES(1), .FLUSH_CYCLES(2), .NOP(32'h0000_0000)) dutA (
    .clock (clock),
    .reset (reset),
    .bus   (busA)
  );

  ifid_hazard_buff #(.STALL_CYCLES(3), .FLUSH_CYCLES(1), .NOP(32'h0000_0000)) dutB (
    .clock (clock),
    .reset (reset),
    .bus   (busB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    @(negedge clock);
    busA.iPC          = v.pc;
    busA.iInstr       = v.instr;
    busA.iValid       = v.valid;
    busA.iStall       = v.stall;
    busA.iBranchTaken = v.br;
    busA.iEXmemRead   = v.memRead;
    busA.iEXRd        = v.rd;
    #1;
    checkOutput($sformatf("v%0d pcwrite", idx), 32'(busA.oPCWrite), 32'(v.expPCWrite));
    checkOutput($sformatf("v%0d bubble", idx), 32'(busA.oBubble), 32'(v.expBubble));
    sbQ.push_back('{v.expPC, v.expInstr, v.expValid, v.expCount, idx});
    @(posedge clock);
    #1;
    e = sbQ.pop_front();
    checkOutput($sformatf("v%0d pc", e.idx), busA.oPC, e.pc);
    checkOutput($sformatf("v%0d instr", e.idx), busA.oInstr, e.instr);
    checkOutput($sformatf("v%0d valid", e.idx), 32'(busA.oValid), 32'(e.valid));
    checkOutput($sformatf("v%0d count", e.idx), 32'(busA.oStallCount), 32'(e.cnt));
  endtask

  task automatic driveB(input logic [31:0] pc, input logic [31:0] instr, input logic valid,
                        input logic stall, input logic memRead, input logic [5:0] rd);
    busB.iPC          = pc;
    busB.iInstr       = instr;
    busB.iValid       = valid;
    busB.iStall       = stall;
    busB.iBranchTaken = 1'b0;
    busB.iEXmemRead   = memRead;
    busB.iEXRd        = rd;
  endtask

  task automatic checkB(input string tag, input logic expPCWrite, input logic expBubble);
    checkOutput({tag, " pcwrite"}, 32'(busB.oPCWrite), 32'(expPCWrite));
    checkOutput({tag, " bubble"}, 32'(busB.oBubble), 32'(expBubble));
  endtask

  task automatic checkBRegs(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic [15:0] cnt);
    checkOutput({tag, " pc"}, busB.oPC, pc);
    checkOutput({tag, " instr"}, busB.oInstr, instr);
    checkOutput({tag, " count"}, 32'(busB.oStallCount), 32'(cnt));
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    reset        = 1'b1;
    busA.iPC = '0; busA.iInstr = '0; busA.iValid = 1'b0; busA.iStall = 1'b0;
    busA.iBranchTaken = 1'b0; busA.iEXmemRead = 1'b0; busA.iEXRd = '0;
    driveB(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);

    //              pc        instr         v     st    br    mr    rd     pcw   bub   ePC       eInstr  eV    eCnt
    vecs.push_back('{32'h00, I0,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h00, I0,    1'b1, 16'd0});
    vecs.push_back('{32'h04, I1,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h04, I1,    1'b1, 16'd0});
    vecs.push_back('{32'h08, I2,            1'b1, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 32'h04, I1,    1'b1, 16'd1});
    vecs.push_back('{32'h08, I0,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h08, I0,    1'b1, 16'd1});
    vecs.push_back('{32'h0C, I2,            1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b1, 1'b0, 32'h0C, I2,    1'b1, 16'd1});
    vecs.push_back('{32'h10, I1,            1'b1, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1, 32'h0C, I2,    1'b1, 16'd2});
    vecs.push_back('{32'h10, I1,            1'b1, 1'b0, 1'b0, 1'b1, 6'd4, 1'b1, 1'b0, 32'h10, I1,    1'b1, 16'd2});
    vecs.push_back('{32'h14, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h18, I1,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h18, I1,    1'b1, 16'd2});
    vecs.push_back('{32'h1C, I2,            1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h18, I1,    1'b1, 16'd2});
    vecs.push_back('{32'h1C, I2,            1'b1, 1'b1, 1'b0, 1'b1, 6'd5, 1'b0, 1'b1, 32'h18, I1,    1'b1, 16'd2});
    vecs.push_back('{32'h1C, 32'hDEADBEEF,  1'b1, 1'b0, 1'b1, 1'b1, 6'd5, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h20, I2,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h18, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h24, I2,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h24, I2,    1'b1, 16'd2});
    vecs.push_back('{32'h28, I1,            1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h2C, I1,            1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 32'h24, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h2C, I1,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h30, I0,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h30, I0,    1'b1, 16'd2});
    vecs.push_back('{32'h34, I1,            1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h34, I1,            1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h34, I1,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 16'd2});
    vecs.push_back('{32'h38, I2,            1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 32'h38, I2,    1'b1, 16'd2});

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset pcwrite", 32'(busA.oPCWrite), 32'd1);
    checkOutput("reset bubble", 32'(busA.oBubble), 32'd0);
    checkOutput("reset pc", busA.oPC, 32'h0);
    checkOutput("reset instr", busA.oInstr, 32'h0);
    checkOutput("reset valid", 32'(busA.oValid), 32'd0);
    checkOutput("reset count", 32'(busA.oStallCount), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Hold a load-use hazard long enough to walk the counter into saturation
    @(negedge clock);
    busA.iEXmemRead = 1'b1;
    busA.iEXRd      = 6'd3;
    repeat (65532) @(posedge clock);
    #1;
    checkOutput("sat near", 32'(busA.oStallCount), 32'h0000_FFFE);
    repeat (3) @(posedge clock);
    #1;
    checkOutput("sat top", 32'(busA.oStallCount), 32'h0000_FFFF);
    checkOutput("sat pcwrite", 32'(busA.oPCWrite), 32'd0);
    checkOutput("sat bubble", 32'(busA.oBubble), 32'd1);
    @(negedge clock);
    busA.iEXmemRead = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("sat hold", 32'(busA.oStallCount), 32'h0000_FFFF);
    checkOutput("sat valid", 32'(busA.oValid), 32'd1);

    // Three-cycle stall with an external freeze in the middle of it
    @(negedge clock);
    driveB(32'h100, I1, 1'b1, 1'b0, 1'b0, 6'd0);
    @(negedge clock);
    driveB(32'h104, I2, 1'b1, 1'b0, 1'b1, 6'd7);
    #1;
    checkB("B hazard", 1'b0, 1'b1);
    @(posedge clock);
    #1;
    checkBRegs("B enter", 32'h100, I1, 16'd1);
    @(negedge clock);
    driveB(32'h104, I2, 1'b1, 1'b1, 1'b0, 6'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkB($sformatf("B freeze%0d", k), 1'b0, 1'b1);
      @(posedge clock);
      #1;
      checkBRegs($sformatf("B freeze%0d", k), 32'h100, I1, 16'd1);
      @(negedge clock);
    end
    driveB(32'h104, I2, 1'b1, 1'b0, 1'b0, 6'd0);
    #1;
    checkB("B stall2", 1'b0, 1'b1);
    @(posedge clock);
    #1;
    checkBRegs("B stall2", 32'h100, I1, 16'd2);
    @(negedge clock);
    #1;
    checkB("B stall3", 1'b0, 1'b1);
    @(posedge clock);
    #1;
    checkBRegs("B stall3", 32'h100, I1, 16'd3);
    @(negedge clock);
    #1;
    checkB("B resume", 1'b1, 1'b0);
    @(posedge clock);
    #1;
    checkBRegs("B resume", 32'h104, I2, 16'd3);

    // Reset landing while the FSM sits in STALL
    @(negedge clock);
    driveB(32'h108, I0, 1'b1, 1'b0, 1'b1, 6'd3);
    @(posedge clock);
    #1;
    checkBRegs("B hazard2", 32'h104, I2, 16'd4);
    @(negedge clock);
    reset = 1'b1;
    driveB(32'h108, I0, 1'b1, 1'b0, 1'b0, 6'd0);
    #1;
    checkB("B in reset", 1'b1, 1'b0);
    @(posedge clock);
    #1;
    checkBRegs("B after reset", 32'h0, 32'h0, 16'd0);
    checkOutput("B after reset valid", 32'(busB.oValid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkB("B run", 1'b1, 1'b0);
    @(posedge clock);
    #1;
    checkBRegs("B run", 32'h108, I0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/ifid_hazard_buff.md
Name: ifid_hazard_buff

Overview:
- IF/ID pipeline register with integrated hazard control. Sits between instruction fetch and decode, directly upstream of the ID/EX buffer.
- Captures fetched PC and instruction each cycle.
- Inserts load-use stalls, with PC freeze plus a bubble request to ID/EX.
- Squashes wrong-path instructions on a taken branch.
- Keeps a saturating stall-cycle counter.

Parameters:
- STALL_CYCLES, 1, bubble cycles inserted per load-use hazard (1..7).
- FLUSH_CYCLES, 1, cycles of incoming instructions discarded after a taken branch (1..7).
- NOP, 32'h0000_0000, instruction word emitted when invalid.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- iPC  in  32  PC of fetched instruction
- iInstr  in  32  fetched instruction
- iValid  in  1  fetch output valid
- iStall  in  1  external freeze (memory busy); holds all state
- iBranchTaken  in  1  EX resolved a taken branch this cycle
- iEXmemRead  in  1  instruction currently in ID/EX is a load
- iEXRd  in  6  destination register of that load
- oPC  out  32  registered PC to decode
- oInstr  out  32  registered instruction to decode
- oValid  out  1  oInstr is a live instruction
- oPCWrite  out  1  PC update enable (combinational)
- oBubble  out  1  ID/EX must load zeroed control fields (combinational)
- oStallCount  out  16  saturating count of hazard-stall cycles

Behaviour:
- Field decode of the held instruction: rs = oInstr[21:16], rt = oInstr[15:10]. Register 0 never causes a hazard.
- hazard = state==RUN && oValid && iEXmemRead && iEXRd!=0 && (iEXRd==rs || iEXRd==rt).
- Reset is synchronous and active-high. On reset: oPC=0, oInstr=NOP, oValid=0, oStallCount=0, state=RUN, counter=0.
  - Combinational outputs during and after reset: oPCWrite=1, oBubble=0.
- Latency: one cycle from fetch inputs to oPC/oInstr/oValid.
- FSM states: RUN, STALL, FLUSH. 3-bit down-counter cnt.
- Per-edge priority: reset > iBranchTaken > iStall > hazard > normal load.
- RUN:
  - iBranchTaken: oInstr<=NOP, oValid<=0, oPC held.
    - FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1, go to FLUSH.
    - Otherwise stay in RUN.
  - iStall: all registers hold.
  - hazard: oPC/oInstr/oValid hold.
    - STALL_CYCLES>1: cnt<=STALL_CYCLES-1, go to STALL.
    - Otherwise stay in RUN; the hazard re-evaluates next cycle and is normally cleared because ID/EX now holds the bubble.
  - Otherwise: oPC<=iPC, oInstr<=iValid?iInstr:NOP, oValid<=iValid.
- STALL: registers hold.
  - cnt>0: cnt decrements; at cnt==0 go to RUN (the cycle after reaching 0).
  - iBranchTaken overrides: flush as in RUN and go to FLUSH or RUN.
  - iStall freezes cnt.
- FLUSH: incoming fetch discarded; oValid=0, oInstr=NOP.
  - cnt decrements; at 0 go to RUN.
  - A new iBranchTaken reloads cnt with FLUSH_CYCLES-1.
  - iStall freezes cnt.
- oPCWrite = !(iStall || hazard || state==STALL). A taken branch forces oPCWrite=1 (redirect must land).
- oBubble = (hazard || state==STALL) && !iBranchTaken.
- oStallCount increments once per cycle in which oBubble=1 and iStall=0. It saturates at 16'hFFFF and never wraps.
- Reset mid-STALL or mid-FLUSH returns to RUN on the same edge; the counter is cleared.

Decomposition:
- Shared package cpu_pkg:
  - field-slice constants RS_HI/RS_LO/RT_HI/RT_LO.
  - NOP word.
  - register-index width (6).
  - state enum {RUN, STALL, FLUSH}.
- One natural sub-module: hazard_detect (combinational load-use compare). It produces hazard from oInstr, oValid, iEXmemRead and iEXRd.
- Everything else stays in the top module.

Test Plan:
- Reset then stream: iValid=1 with PCs 0x0, 0x4, 0x8 -> oPC follows one cycle later, oValid=1, oPCWrite=1, oBubble=0.
- Load-use: oInstr rs=5, iEXmemRead=1, iEXRd=5, STALL_CYCLES=1 -> one cycle with oPCWrite=0 and oBubble=1, oInstr held, oStallCount=1, then resumes loading. Same case with iEXRd=0 -> no stall.
- Taken branch: iBranchTaken=1 while iInstr=0xDEADBEEF -> next cycle oValid=0, oInstr=0. With FLUSH_CYCLES=2, one further incoming instruction is also discarded.
- Simultaneous hazard and iBranchTaken -> flush wins; oBubble=0, oPCWrite=1, oStallCount unchanged.
- iStall=1 for 3 cycles during STALL (STALL_CYCLES=3) -> oPC/oInstr/cnt frozen and oStallCount frozen; the stall completes after release.
- Preload oStallCount near 16'hFFFE, force 3 hazard cycles -> count saturates at 16'hFFFF. Reset asserted mid-STALL -> RUN next cycle, all outputs at reset values.
